// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the elastic register chain: occupancy width helper
// and the occupancy-counter update encoding.
package pipe_reg_chain_pkg;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2,
    OCC_CLR  = 2'd3
  } occ_op_e;

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One elastic stage: a valid bit plus a data word. Data only captures when the
// incoming entry is valid, so a drained stage keeps its last contents.
module pipe_reg_stage #(
  parameter int                WIDTH       = 3,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Flush wins over a simultaneous load and leaves the data word untouched.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (load_i) begin
      v_d = valid_i;
      if (valid_i) d_d = data_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= RESET_VALUE;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH elastic register stages with valid/ready handshake, flush and
// a registered occupancy count. Ready ripples combinationally from the output.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             xfer_in, xfer_out;

  // A stage may advance when it is empty or the stage after it advances.
  always_comb begin
    adv          = '0;
    adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !v[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0] & !flush;
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             stg_valid;
    logic [WIDTH-1:0] stg_data;

    if (k == 0) begin : g_head
      assign stg_valid = xfer_in;
      assign stg_data  = in_data;
    end else begin : g_body
      assign stg_valid = v[k-1];
      assign stg_data  = d[k-1];
    end

    pipe_reg_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .flush_i (flush),
      .load_i  (adv[k]),
      .valid_i (stg_valid),
      .data_i  (stg_data),
      .valid_o (v[k]),
      .data_o  (d[k])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Occupancy tracks transfers rather than recounting the valid bits.
  occ_op_e          occ_op;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_op = OCC_HOLD;
    if (flush)                    occ_op = OCC_CLR;
    else if (xfer_in && !xfer_out) occ_op = OCC_INC;
    else if (!xfer_in && xfer_out) occ_op = OCC_DEC;
  end

  always_comb begin
    occ_d = occ_q;
    unique case (occ_op)
      OCC_INC:  occ_d = occ_q + OCC_W'(1);
      OCC_DEC:  occ_d = occ_q - OCC_W'(1);
      OCC_CLR:  occ_d = '0;
      default:  occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;

  a_occ_matches_valids: assert property (
    @(posedge clock) disable iff (reset) occupancy == OCC_W'($countones(v))
  );

endmodule
